vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

Owns the 16 x 8 display register file that the VGA controller scans, and shares its single access port between the VGA read stream and one host requester (update logic for the values drawn on screen). VGA reads have priority. Host reads and writes use a four-phase req/ack handshake and are served in idle slots. A bounded-wait counter steals one VGA slot so the host is never starved. The block sits between ControlVGACentral (MemAddrOut/MemDataIN) and the host-side update logic.

## Interface
- AW, 4, address width; depth is 2^AW entries.
- DW, 8, data width.
- MAX_WAIT, 7, number of blocked host cycles tolerated before a slot is stolen (0..15).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- VgaRd  in  1  VGA read strobe for this cycle.
- VgaAddr  in  AW  VGA read address.
- VgaData  out  DW  registered VGA read data.
- VgaStall  out  1  registered; high when the previous VGA read was not served and VgaData was held.
- HReq  in  1  host request, level, four-phase.
- HWe  in  1  1 = write, 0 = read; sampled with HReq.
- HAddr  in  AW  host address; sampled with HReq.
- HWData  in  DW  host write data; sampled with HReq.
- HAck  out  1  host acknowledge.
- HRData  out  DW  host read data; valid while HAck = 1 after a read.

## Operation
- Storage is 2^AW registers of DW bits. There is one access per cycle: one read or one write.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if HReq = 1 at the edge, latch HWe/HAddr/HWData, clear wait_cnt, go to WAIT.
  - WAIT: host is granted when VgaRd = 0 or wait_cnt == MAX_WAIT.
    - On grant: a write updates mem[addr]; a read loads HRData with mem[addr]. Go to ACK.
    - Otherwise wait_cnt increments (saturates at MAX_WAIT) and the FSM stays in WAIT.
  - ACK: HAck = 1. Stay in ACK while HReq = 1. Go to IDLE on the first edge where HReq = 0.
- VGA path:
  - When VgaRd = 1 and the host is not granted this cycle: VgaData <= mem[VgaAddr], VgaStall <= 0.
  - When the host steals the slot (VgaRd = 1 and host granted): VgaData holds its value, VgaStall <= 1.
  - When VgaRd = 0: VgaData holds, VgaStall <= 0.
- The host latch decouples the host bus. HAddr, HWData and HWe may change after the request is sampled in IDLE.
- HReq dropping during WAIT has no effect. The latched operation completes, and ACK exits on the next edge.

## Timing
- Reset values: all memory entries 0, VgaData 0, VgaStall 0, HAck 0, HRData 0, FSM IDLE, wait_cnt 0. Reset takes effect immediately (asynchronous) and discards any pending host operation, including a mid-WAIT request.
- VGA read latency is 1 cycle: address at edge t gives data after edge t+1.
- Host minimum latency is 2 edges, from HReq sampled to HAck high. Worst case is MAX_WAIT + 2 edges.
- Write-then-read ordering:
  - A host write granted at edge t is visible to a VGA read issued at edge t+1.
  - A VGA read and a host write to the same address on a non-steal cycle: VGA wins and gets the old data; the write lands later.
- With MAX_WAIT = 0, every host request is granted on its first WAIT cycle regardless of VgaRd.
- A new HReq is not accepted until the FSM has returned to IDLE (HReq low seen in ACK).

## Test plan
- Reset, then VgaRd = 1 for addresses 0..15 -> VgaData = 0 each cycle, VgaStall = 0, HAck = 0.
- VgaRd = 0; host write addr 3 = 0x1E; host read addr 3 -> HAck high 2 edges after each request; HRData = 0x1E during the read ACK.
- VgaRd held at 1 continuously; host write addr 8 = 0x32 with MAX_WAIT = 7 -> grant on the 8th WAIT cycle; VgaStall = 1 for exactly that one cycle with VgaData unchanged; next VGA read of addr 8 returns 0x32.
- Host write addr 5 = 0x03 while a VGA read of addr 5 is in the same non-steal cycle -> VGA returns the old value 0x00; the write completes in the next free slot; a later VGA read returns 0x03.
- Hold HReq high for 4 cycles after HAck -> HAck stays high; a second request is not accepted until HReq = 0 has been sampled.
- Assert RESET low while the FSM is in WAIT with a write pending -> all outputs 0 immediately; after release, the target entry still reads 0 and HAck stays 0.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: VGA read stream and host req/ack bus into the display register file
interface vga_mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          VgaRd;
  logic [AW-1:0] VgaAddr;
  logic [DW-1:0] VgaData;
  logic          VgaStall;
  logic          HReq;
  logic          HWe;
  logic [AW-1:0] HAddr;
  logic [DW-1:0] HWData;
  logic          HAck;
  logic [DW-1:0] HRData;
  modport master (
    output VgaRd, VgaAddr, HReq, HWe, HAddr, HWData,
    input  VgaData, VgaStall, HAck, HRData
  );
  modport slave (
    input  VgaRd, VgaAddr, HReq, HWe, HAddr, HWData,
    output VgaData, VgaStall, HAck, HRData
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: display register file shared between VGA scan reads (priority) and a bounded-wait host port
module vga_mem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int MAX_WAIT = 7
) (
  input logic              CLK,
  input logic              RESET,
  vga_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_t        state, state_nx;
  logic [3:0]    wait_cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q, vdata_q;
  logic          stall_q;
  logic [DW-1:0] mem [2**AW];
  logic          grant;
  always_comb begin
    grant = state == WAIT && (!bus.VgaRd || wait_cnt == MW);
    state_nx = state == IDLE ? (bus.HReq ? WAIT : IDLE) :
               state == WAIT ? (grant ? ACK : WAIT) :
               (bus.HReq ? ACK : IDLE);
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      vdata_q  <= '0;
      stall_q  <= 1'b0;
      mem      <= '{default: '0};
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.HReq) begin
        we_q     <= bus.HWe;
        addr_q   <= bus.HAddr;
        wdata_q  <= bus.HWData;
        wait_cnt <= '0;
      end else if (state == WAIT && !grant && wait_cnt != MW) wait_cnt <= wait_cnt + 4'd1;
      if (grant && we_q) mem[addr_q] <= wdata_q;
      if (grant && !we_q) rdata_q <= mem[addr_q];
      // a stolen slot leaves VgaData untouched and flags the stall instead
      if (bus.VgaRd && !grant) vdata_q <= mem[bus.VgaAddr];
      stall_q <= bus.VgaRd && grant;
    end
  assign bus.VgaData  = vdata_q;
  assign bus.VgaStall = stall_q;
  assign bus.HAck     = state == ACK;
  assign bus.HRData   = rdata_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench for vga_mem_arbiter driven by directed VGA/host vectors
module tb_vga_mem_arbiter;
  typedef struct {logic rd; logic [7:0] data; int at;} hexp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic rd_seen = 1'b0;
  logic ack_q = 1'b0;
  logic [8:0] vq[$];
  hexp_t hq[$];
  vga_mem_arbiter_if #(.AW(4), .DW(8)) bus ();
  vga_mem_arbiter #(.AW(4), .DW(8), .MAX_WAIT(7)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(logic rd, logic [3:0] va, logic [7:0] vexp, logic vst,
                      logic req, logic we, logic [3:0] ha, logic [7:0] hd);
    bus.VgaRd = rd;
    bus.VgaAddr = va;
    bus.HReq = req;
    bus.HWe = we;
    bus.HAddr = ha;
    bus.HWData = hd;
    if (rd) vq.push_back({vst, vexp});
    @(posedge CLK);
    #1;
  endtask
  task automatic expect_host(logic rd, logic [7:0] data, int at);
    hq.push_back('{rd, data, at});
  endtask
  task automatic host_free(logic we, logic [3:0] a, logic [7:0] d, logic [7:0] rexp);
    expect_host(!we, rexp, cyc + 2);
    step(0, 0, 0, 0, 1, we, a, d);
    step(0, 0, 0, 0, 1, we, a, d);
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    rd_seen <= bus.VgaRd && RESET;
  end
  always @(negedge CLK) begin : monitor
    logic [8:0] v;
    hexp_t h;
    if (rd_seen && RESET) begin
      if (vq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL vga_unexpected: read result data %0h with nothing expected", bus.VgaData);
      end else begin
        v = vq.pop_front();
        chk("vga_data", {24'd0, bus.VgaData}, {24'd0, v[7:0]});
        chk("vga_stall", {31'd0, bus.VgaStall}, {31'd0, v[8]});
      end
    end
    if (bus.HAck && !ack_q) begin
      if (hq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL hack_unexpected: HAck rose at edge %0d with nothing expected", cyc);
      end else begin
        h = hq.pop_front();
        chk("hack_edge", cyc, h.at);
        if (h.rd) chk("hrdata", {24'd0, bus.HRData}, {24'd0, h.data});
      end
    end
    ack_q = bus.HAck;
  end
  initial begin
    bus.VgaRd = 0;
    bus.VgaAddr = 0;
    bus.HReq = 0;
    bus.HWe = 0;
    bus.HAddr = 0;
    bus.HWData = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_vgadata", {24'd0, bus.VgaData}, 0);
    chk("rst_stall", {31'd0, bus.VgaStall}, 0);
    chk("rst_hack", {31'd0, bus.HAck}, 0);
    chk("rst_hrdata", {24'd0, bus.HRData}, 0);
    RESET = 1;
    for (int a = 0; a < 16; a++) step(1, 4'(a), 8'h00, 0, 0, 0, 0, 0);
    chk("idle_hack", {31'd0, bus.HAck}, 0);
    host_free(1, 3, 8'h1E, 8'h00);
    host_free(0, 3, 8'h00, 8'h1E);
    expect_host(0, 0, cyc + 9);
    for (int k = 0; k < 8; k++) step(1, 3, 8'h1E, 0, 1, 1, 8, 8'h32);
    step(1, 0, 8'h1E, 1, 1, 1, 8, 8'h32);
    step(1, 8, 8'h32, 0, 0, 0, 0, 0);
    expect_host(0, 0, cyc + 3);
    step(1, 5, 8'h00, 0, 1, 1, 5, 8'h03);
    step(1, 5, 8'h00, 0, 1, 0, 9, 8'hFF);
    step(0, 0, 8'h00, 0, 1, 0, 9, 8'hFF);
    step(1, 5, 8'h03, 0, 0, 0, 0, 0);
    step(1, 9, 8'h00, 0, 0, 0, 0, 0);
    expect_host(1, 8'h32, cyc + 2);
    step(0, 0, 0, 0, 1, 0, 8, 0);
    step(0, 0, 0, 0, 1, 0, 8, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, 1, 8, 8'hAA);
      chk("ack_hold", {31'd0, bus.HAck}, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ack_release", {31'd0, bus.HAck}, 0);
    step(1, 8, 8'h32, 0, 0, 0, 0, 0);
    step(1, 8, 8'h32, 0, 1, 1, 2, 8'h55);
    step(1, 8, 8'h32, 0, 1, 1, 2, 8'h55);
    @(negedge CLK);
    #1;
    bus.HReq = 0;
    bus.VgaRd = 0;
    RESET = 0;
    #1;
    chk("async_vgadata", {24'd0, bus.VgaData}, 0);
    chk("async_stall", {31'd0, bus.VgaStall}, 0);
    chk("async_hack", {31'd0, bus.HAck}, 0);
    chk("async_hrdata", {24'd0, bus.HRData}, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1;
    step(1, 2, 8'h00, 0, 0, 0, 0, 0);
    step(1, 3, 8'h00, 0, 0, 0, 0, 0);
    step(1, 8, 8'h00, 0, 0, 0, 0, 0);
    step(1, 5, 8'h00, 0, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 0, 0);
    chk("post_rst_hack", {31'd0, bus.HAck}, 0);
    repeat (2) @(negedge CLK);
    #1;
    chk("vga_queue_drained", vq.size(), 0);
    chk("host_queue_drained", hq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
